// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   - FSM state encoding (IDLE/RUN/DONE)
//   - BCD constants (largest legal digit, decimal correction)
//   - is_bcd_digit: 1 when a 4-bit nibble is a legal decimal digit
package bcd_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_digit_unit.sv
// Single-digit BCD add/subtract stage (purely combinational).
// Ports:
//   a_i       4   digit of operand A
//   b_i       4   digit of operand B
//   sub_i     1   1 = use the nine's complement of b_i
//   carry_i   1   decimal carry into this digit
//   digit_o   4   corrected BCD result digit
//   carry_o   1   decimal carry out of this digit
module bcd_digit_unit
  import bcd_defs::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  input  logic       carry_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] bd;
  logic [4:0] t;
  logic [4:0] t_corr;

  // Nine's complement wraps mod 16 for illegal digits; the invalid flag
  // at the top level tells the user the result is meaningless then.
  assign bd     = sub_i ? (BCD_MAX - b_i) : b_i;
  assign t      = {1'b0, a_i} + {1'b0, bd} + {4'b0000, carry_i};
  assign t_corr = t + {1'b0, BCD_CORR};

  always_comb begin
    digit_o = t[3:0];
    carry_o = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      digit_o = t_corr[3:0];
      carry_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first,
// one shared correct-by-6 stage regardless of DIGITS.
// Ports:
//   clk      1          rising-edge clock
//   reset    1          synchronous active-high reset
//   start    1          request pulse, honoured only in IDLE
//   sub      1          0 = A+B+cin, 1 = A-B
//   cin      1          decimal carry-in (add mode)
//   a, b     4*DIGITS   packed BCD operands, digit 0 in [3:0]
//   busy     1          operation in progress
//   done     1          one-cycle pulse, result valid
//   sum      4*DIGITS   packed BCD result
//   cout     1          add: carry-out; sub: 1 = no borrow
//   invalid  1          some operand digit was > 9
module bcd_serial_addsub
  import bcd_defs::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NSLOT = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            invalid_q, invalid_d;

  // Digit views padded to a power of two so the index never leaves range.
  logic [3:0] a_dig [NSLOT];
  logic [3:0] b_dig [NSLOT];
  logic [DIGITS-1:0] bad_a, bad_b;

  logic [3:0] unit_digit;
  logic       unit_carry;
  logic       running;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < DIGITS) begin : g_used
        assign a_dig[gi] = a_q[gi*4 +: 4];
        assign b_dig[gi] = b_q[gi*4 +: 4];
      end else begin : g_pad
        assign a_dig[gi] = 4'd0;
        assign b_dig[gi] = 4'd0;
      end
    end

    // Validity is judged on the operands being latched at start.
    for (gi = 0; gi < DIGITS; gi++) begin : g_valid
      assign bad_a[gi] = !is_bcd_digit(a[gi*4 +: 4]);
      assign bad_b[gi] = !is_bcd_digit(b[gi*4 +: 4]);
    end
  endgenerate

  bcd_digit_unit u_digit (
    .a_i     (a_dig[idx_q]),
    .b_i     (b_dig[idx_q]),
    .sub_i   (sub_q),
    .carry_i (carry_q),
    .digit_o (unit_digit),
    .carry_o (unit_carry)
  );

  assign running = (state_q == ST_RUN);

  // Only the digit currently addressed is overwritten; the rest hold.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sum
      assign sum_d[gi*4 +: 4] = (running && (idx_q == IDXW'(gi)))
                              ? unit_digit : sum_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          idx_d     = '0;
          a_d       = a;
          b_d       = b;
          sub_d     = sub;
          // Subtraction is A + nines(B) + 1, i.e. ten's complement.
          carry_d   = sub ? 1'b1 : cin;
          invalid_d = |{bad_a, bad_b};
        end
      end
      ST_RUN: begin
        carry_d = unit_carry;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          cout_d  = unit_carry;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

  logic        clk;
  logic        reset;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  logic        start1, sub1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1, invalid1;
  logic [3:0]  sum1;

  int total = 0;
  int bad   = 0;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .invalid(invalid)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .invalid(invalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the 4-digit DUT and check timing and result.
  task automatic run_op(input string tag, input logic [15:0] ta,
                        input logic [15:0] tb_v, input logic ts, input logic tc,
                        input logic [15:0] esum, input logic ecout,
                        input logic einv);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    check({tag, ".latency"}, cyc, 5);
    check({tag, ".busy_cycles"}, busy_cnt, 4);
    check({tag, ".sum"}, sum, esum);
    check({tag, ".cout"}, cout, ecout);
    check({tag, ".invalid"}, invalid, einv);
    $display("op %s a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d invalid=%0d cycles=%0d",
             tag, ta, tb_v, ts, tc, sum, cout, invalid, cyc);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.sum", sum, 0);
    check("reset.cout", cout, 0);
    check("reset.invalid", invalid, 0);
    reset = 1'b0;

    run_op("add_basic", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("add_ovf",   16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin",   16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op("sub_noborrow", 16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0);
    run_op("sub_borrow",   16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
    // A digit: 4+0=4; A+0=10 -> 0 carry; 2+0+1=3; 1 -> 1304
    run_op("invalid_op", 16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h1304, 1'b0, 1'b1);
    run_op("valid_after", 16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Start pulses during RUN must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 2; i <= 12; i++) begin
      if (i == 2 || i == 3) begin
        start = 1'b1; a = 16'h9999; b = 16'h9999;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("ignore_start.sum", sum, 16'h6912);
      end
    end
    start = 1'b0;
    check("ignore_start.done_pulses", done_cnt, 1);
    check("ignore_start.busy_idle", busy, 0);
    $display("op ignore_start done_pulses=%0d sum=%h", done_cnt, sum);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset.busy", busy, 0);
    check("midreset.sum", sum, 0);
    check("midreset.done", done, 0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset.no_done", done_cnt, 0);
    $display("op midreset busy=%0d sum=%h done_pulses=%0d", busy, sum, done_cnt);
    run_op("after_reset", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);

    // Single-digit build.
    @(negedge clk);
    a1 = 4'h7; b1 = 4'h5; sub1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("d1.latency", cyc, 2);
    check("d1.sum", sum1, 4'h2);
    check("d1.cout", cout1, 1'b1);
    check("d1.invalid", invalid1, 1'b0);
    $display("op d1 a=7 b=5 -> sum=%h cout=%0d cycles=%0d", sum1, cout1, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
